// File: rtl/vme_bus_arbiter.sv
// Two-master round-robin arbiter in front of a VME-style register-map slave port.
// Each access runs strobe -> wait for the matching done (or watchdog expiry) -> return.
module vme_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  // master 0
  input  logic [18:0] m0_addr,
  input  logic [15:0] m0_wdata,
  input  logic        m0_rd,
  input  logic        m0_wr,
  output logic [15:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  // master 1
  input  logic [18:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic        m1_rd,
  input  logic        m1_wr,
  output logic [15:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  // register-map slave port
  output logic [18:0] VMEAddr,
  output logic [15:0] VMEWrData,
  output logic        VMERdMem,
  output logic        VMEWrMem,
  input  logic [15:0] VMERdData,
  input  logic        VMERdDone,
  input  logic        VMEWrDone
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(TIMEOUT_CYCLES);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_grant;       // 0 = M0, 1 = M1
  logic              r_last_grant;
  logic              r_is_rd;
  logic [18:0]       r_addr;
  logic [15:0]       r_wdata;
  logic [TO_W-1:0]   r_cnt;
  logic [15:0]       r_m0_rdata;
  logic [15:0]       r_m1_rdata;
  logic              r_m0_err;
  logic              r_m1_err;

  logic              w_req0;
  logic              w_req1;
  logic              w_pick;
  logic              w_ack;
  logic              w_expire;
  logic [TO_W-1:0]   w_cnt_inc;

  assign w_req0    = m0_rd | m0_wr;
  assign w_req1    = m1_rd | m1_wr;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Only the acknowledge matching the access kind counts, and only while waiting.
  assign w_ack    = (r_state == S_WAIT) & (r_is_rd ? VMERdDone : VMEWrDone);
  assign w_expire = (r_state == S_WAIT) & (w_cnt_inc == TIMEOUT_VAL);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_next_state = r_state;
    w_pick       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_next_state = S_ISSUE;
          w_pick       = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (w_ack | w_expire) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the request latch and return registers are reset as well, so the
  // slave port and master outputs read all-zero straight out of reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_is_rd      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_m0_err     <= 1'b0;
      r_m1_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_grant <= w_pick;
            r_addr  <= w_pick ? m1_addr  : m0_addr;
            r_wdata <= w_pick ? m1_wdata : m0_wdata;
            // rd and wr together resolve to a read
            r_is_rd <= w_pick ? m1_rd    : m0_rd;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_ack) begin
            if (r_grant) begin
              if (r_is_rd) r_m1_rdata <= VMERdData;
              r_m1_err <= 1'b0;
            end else begin
              if (r_is_rd) r_m0_rdata <= VMERdData;
              r_m0_err <= 1'b0;
            end
          end else if (w_expire) begin
            if (r_grant) begin
              r_m1_rdata <= 16'h0000;
              r_m1_err   <= 1'b1;
            end else begin
              r_m0_rdata <= 16'h0000;
              r_m0_err   <= 1'b1;
            end
          end
        end
        S_DONE:  r_last_grant <= r_grant;
        default: ;
      endcase
    end
  end

  assign VMEAddr   = r_addr;
  assign VMEWrData = r_wdata;
  assign VMERdMem  = (r_state == S_ISSUE) &  r_is_rd;
  assign VMEWrMem  = (r_state == S_ISSUE) & ~r_is_rd;

  assign m0_done   = (r_state == S_DONE) & ~r_grant;
  assign m1_done   = (r_state == S_DONE) &  r_grant;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_err    = r_m0_err;
  assign m1_err    = r_m1_err;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Bench for vme_bus_arbiter: directed scenarios plus randomized batches, checked
// against a transaction-level model (alternating grants, slave memory, latency rule).
`timescale 1ns/1ps
module tb_vme_bus_arbiter;

  localparam int T       = 4;
  localparam int OP_RD   = 0;
  localparam int OP_WR   = 1;
  localparam int RND     = -1;

  typedef struct {
    int          m;
    bit          rd;
    logic [18:0] addr;
    logic [15:0] wdata;
    int          lat;     // slave ack delay after strobe, 0 = never
  } txn_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [18:0] m0_addr = '0, m1_addr = '0;
  logic [15:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_rd = 1'b0, m0_wr = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [18:0] VMEAddr;
  logic [15:0] VMEWrData;
  logic        VMERdMem, VMEWrMem;
  logic [15:0] VMERdData = '0;
  logic        VMERdDone = 1'b0, VMEWrDone = 1'b0;

  vme_bus_arbiter #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rd(m0_rd), .m0_wr(m0_wr),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rd(m1_rd), .m1_wr(m1_wr),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
  );

  always #5 Clk = ~Clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  txn_t        exp_q[$];
  logic [15:0] slave_mem [64];
  logic [15:0] model_mem [64];
  logic [15:0] model_rdata [2];
  int          model_last = 1;
  int          ack_cnt = 0, wrong_cnt = 0, wrong_lat = 0;
  logic        pend_rd = 1'b0;
  logic [5:0]  pend_idx = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to the falling edge, then play the slave for that cycle.
  task automatic step();
    @(negedge Clk);
    cyc++;
    VMERdDone = 1'b0;
    VMEWrDone = 1'b0;
    if (Rst) begin
      ack_cnt   = 0;
      wrong_cnt = 0;
    end else begin
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          if (pend_rd) begin
            VMERdDone = 1'b1;
            VMERdData = slave_mem[pend_idx];
          end else begin
            VMEWrDone = 1'b1;
          end
        end
      end
      if (wrong_cnt > 0) begin
        wrong_cnt--;
        if (wrong_cnt == 0) begin
          if (pend_rd) VMEWrDone = 1'b1;
          else begin
            VMERdDone = 1'b1;
            VMERdData = 16'hDEAD;
          end
        end
      end
      if (VMERdMem || VMEWrMem) begin
        pend_rd  = VMERdMem;
        pend_idx = VMEAddr[5:0];
        if (VMEWrMem) slave_mem[pend_idx] = VMEWrData;
        ack_cnt   = (exp_q.size() > 0) ? exp_q[0].lat : 1;
        wrong_cnt = wrong_lat;
      end
    end
  endtask

  task automatic drive_master(input int m, input txn_t t, input int op);
    if (m == 0) begin
      m0_addr = t.addr; m0_wdata = t.wdata; m0_rd = (op != OP_WR); m0_wr = (op != OP_RD);
    end else begin
      m1_addr = t.addr; m1_wdata = t.wdata; m1_rd = (op != OP_WR); m1_wr = (op != OP_RD);
    end
  endtask

  // Raise requests from the enabled masters together and score every completion.
  task automatic run_batch(input bit en0, input bit en1, input int op0, input int op1,
                           input int lat0, input int lat1, input int wl, input int addr0);
    txn_t t [2];
    txn_t txn;
    int   op, first, start, served, n, strobes, got, exp_lat;
    bit   exp_err;
    for (int m = 0; m < 2; m++) begin
      op = (m == 0) ? op0 : op1;
      if (op < 0) op = $urandom_range(0, 2);
      t[m].m     = m;
      t[m].rd    = (op != OP_WR);
      t[m].addr  = 19'($urandom());
      if (t[m].addr[5:0] == 6'd1) t[m].addr[1] = 1'b1;
      if (m == 0 && addr0 >= 0) t[m].addr = 19'(addr0);
      t[m].wdata = 16'($urandom());
      t[m].lat   = (m == 0) ? lat0 : lat1;
      if (t[m].lat < 0) t[m].lat = $urandom_range(0, T + 1);
      if ((m == 0 && en0) || (m == 1 && en1)) drive_master(m, t[m], op);
    end
    first = (en0 && en1) ? ((model_last == 1) ? 0 : 1) : (en0 ? 0 : 1);
    exp_q.push_back(t[first]);
    if (en0 && en1) exp_q.push_back(t[1 - first]);
    wrong_lat = wl;
    n = exp_q.size();
    start = cyc;
    served = 0;
    strobes = 0;
    for (int c = 0; c < 60 && served < n; c++) begin
      step();
      if ((VMERdMem || VMEWrMem) && exp_q.size() > 0) begin
        strobes++;
        check("strobe_kind", {VMERdMem, VMEWrMem}, exp_q[0].rd ? 2'b10 : 2'b01);
        check("strobe_addr", VMEAddr, exp_q[0].addr);
        if (!exp_q[0].rd) check("strobe_wdata", VMEWrData, exp_q[0].wdata);
      end
      if (m0_done || m1_done) begin
        check("done_exclusive", m0_done & m1_done, 0);
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          got = m1_done ? 1 : 0;
          txn = exp_q.pop_front();
          check("grant_order", got, txn.m);
          exp_err = (txn.lat == 0) || (txn.lat > T);
          exp_lat = exp_err ? 2 + T : 2 + txn.lat;
          if (exp_err) model_rdata[txn.m] = 16'h0000;
          else if (txn.rd) model_rdata[txn.m] = model_mem[txn.addr[5:0]];
          if (!txn.rd) model_mem[txn.addr[5:0]] = txn.wdata;
          check("done_rdata", got ? m1_rdata : m0_rdata, model_rdata[txn.m]);
          check("done_err", got ? m1_err : m0_err, exp_err);
          check("done_latency", cyc - start, exp_lat);
          if (got) begin m1_rd = 1'b0; m1_wr = 1'b0; end
          else begin m0_rd = 1'b0; m0_wr = 1'b0; end
          model_last = got;
          start = cyc + 1;
          served++;
        end
      end
    end
    check("batch_complete", served, n);
    check("strobe_count", strobes, n);
    m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
    wrong_lat = 0;
    exp_q.delete();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t tr;
    bit   en0, en1;
    for (int i = 0; i < 64; i++) begin
      slave_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      model_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    slave_mem[1] = 16'hBEEF;
    model_mem[1] = 16'hBEEF;
    model_rdata[0] = 16'h0000;
    model_rdata[1] = 16'h0000;

    // reset state
    Rst = 1'b1;
    step(); step();
    check("rst_addr", VMEAddr, 0);
    check("rst_wdata", VMEWrData, 0);
    check("rst_strobes", {VMERdMem, VMEWrMem}, 0);
    check("rst_done", {m0_done, m1_done}, 0);
    check("rst_m0", {m0_rdata, m0_err}, 0);
    check("rst_m1", {m1_rdata, m1_err}, 0);
    Rst = 1'b0;
    step();
    check("post_rst_idle", {m0_done, m1_done, VMERdMem, VMEWrMem}, 0);

    // simultaneous writes right after reset: M0 first, then M1
    run_batch(1, 1, OP_WR, OP_WR, 1, 2, 0, RND);

    // M0 read of word 0x00001, ack one cycle after the strobe
    run_batch(1, 0, OP_RD, RND, 1, 0, 0, 1);
    check("t1_rdata_beef", m0_rdata, 16'hBEEF);

    // back-to-back contention: grants alternate
    for (int i = 0; i < 3; i++) run_batch(1, 1, OP_RD, OP_RD, RND, RND, 0, RND);

    // M1 write never acked in time; ack arriving two cycles after done is ignored
    run_batch(0, 1, RND, OP_WR, 0, T + 3, 0, RND);
    for (int i = 0; i < 6; i++) begin
      step();
      check("late_ack_ignored", {m0_done, m1_done, VMERdMem, VMEWrMem}, 0);
    end
    check("late_ack_err_kept", m1_err, 1);

    // read ack on the expiry cycle wins; a write ack during the read is ignored
    run_batch(1, 0, OP_RD, RND, T, 0, 1, RND);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      en0 = 1'($urandom_range(0, 1));
      en1 = en0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_batch(en0, en1, RND, RND, RND, RND, $urandom_range(0, T), RND);
    end

    // reset in the middle of an M0 read
    tr.m = 0; tr.rd = 1'b1; tr.addr = 19'h00123; tr.wdata = 16'h0000; tr.lat = 0;
    exp_q.push_back(tr);
    drive_master(0, tr, OP_RD);
    step(); step(); step();
    Rst = 1'b1;
    #1;
    check("rst_async_addr", VMEAddr, 0);
    step();
    check("midrst_addr", VMEAddr, 0);
    check("midrst_strobes", {VMERdMem, VMEWrMem}, 0);
    check("midrst_done", {m0_done, m1_done}, 0);
    check("midrst_m0", {m0_rdata, m0_err}, 0);
    check("midrst_m1", {m1_rdata, m1_err}, 0);
    Rst = 1'b0;
    m0_rd = 1'b0;
    exp_q.delete();
    model_last = 1;
    model_rdata[0] = 16'h0000;
    model_rdata[1] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_done_after_rst", {m0_done, m1_done, VMERdMem, VMEWrMem}, 0);
    end
    run_batch(0, 1, RND, RND, 2, 2, 0, RND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
